mips32_prog_loader: RTL
=======================

Name: mips32_prog_loader

Overview:
- Byte-stream program loader and the write side of the MIPS32 instruction/data memory. The pipeline reads and executes from that memory.
- It receives one framed program image over a valid/ready byte interface, assembles big-endian 32-bit words and writes them to consecutive memory addresses.
- It checks a frame checksum, then raises cpu_run to release the processor.
- It sits between the host or UART byte source and the memory write port in front of the core.

Parameters:
- ADDR_W, 10, memory word-address width (1024-word memory).
- TIMEOUT_CYC, 65535, inter-byte timeout in clocks. Used only with LOADER_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse; aborts any frame in progress and re-arms the loader.
- in_valid  in  1  byte source has data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  memory write strobe, one-cycle pulse per word.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- busy  out  1  frame reception in progress.
- done  out  1  last frame loaded with good checksum.
- error  out  1  last frame failed.
- err_code  out  2  00 none, 01 checksum, 10 timeout.
- cpu_run  out  1  processor release; high only in DONE.

Behaviour:
- Frame format, in byte order:
  - ADDR_HI, ADDR_LO: start word address, 16-bit big-endian; only bits [ADDR_W-1:0] are used.
  - CNT_HI, CNT_LO: word count N, 16-bit.
  - 4*N payload bytes, each word MSB first.
  - CHK byte: 8-bit sum of all frame bytes including CHK must equal 0x00.
- A byte transfers on a posedge where in_valid && in_ready.
- in_ready = (state in HDR, PAY, CHK) && !start. It is combinational and never depends on in_valid.
- States and transitions:
  - RESET: entered on rst_n=0 or start=1 from any state.
  - HDR: accepts 4 header bytes. If N=0, go to CHK; otherwise go to PAY.
  - PAY: 4th byte of each word, then the next cycle:
    - mem_we=1, mem_addr=current address, mem_wdata=assembled word.
    - Address then increments modulo 2^ADDR_W, so wrap to 0 is silent.
    - After the N-th word, go to CHK.
  - CHK: accept the checksum byte. Running sum 0x00 goes to DONE; otherwise ERR with err_code=01.
  - DONE: done=1, cpu_run=1, in_ready=0. Hold until start.
  - ERR: error=1, cpu_run=0, in_ready=0. Hold until start.
- The byte after RESET goes directly to HDR. RESET lasts one cycle and clears counters, sum and flags, then moves to HDR.
- Write latency: mem_we is asserted exactly 1 clock after the acceptance of the word's 4th byte.
  - Byte acceptance continues without stall, so back-to-back words produce mem_we pulses at most once per 4 accepted bytes.
  - A pending write whose 4th byte was accepted still issues even if start arrives the same cycle as the write slot.
  - No write issues after reset.
- Counters: byte-in-word 2-bit; word counter 16-bit; checksum 8-bit wrapping add.
- busy = state in HDR, PAY, CHK after the first header byte is accepted.
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, err_code=00, cpu_run=0.
- rst_n=0 mid-frame discards partial data. Memory already written is not undone.
- start and in_valid in the same cycle: start wins and the byte is not accepted.

Optional Feature:
- Macro LOADER_TIMEOUT_EN.
- When defined:
  - An idle counter runs whenever busy=1 and no byte is accepted.
  - It resets on each accepted byte.
  - Reaching TIMEOUT_CYC moves to ERR with err_code=10.
  - No timeout applies in HDR before the first byte.
- When undefined: the loader waits indefinitely, and err_code=10 never occurs.

Test Plan:
- Basic load: reset, start, stream 00 00 00 01 28 01 00 0A CC with in_valid held high.
  - One mem_we with mem_addr=0, mem_wdata=0x2801000A, one cycle after byte 0x0A.
  - Then done=1, cpu_run=1, err_code=00.
- Bad checksum: same frame with CHK=0xCD.
  - Write still issued, then error=1, err_code=01, cpu_run=0, in_ready=0.
- Wrap-around (ADDR_W=10): ADDR=0x03FF, N=2, words 0x11111111 and 0x22222222, correct CHK.
  - Writes at 0x3FF then 0x000, then done=1.
- Empty program: 00 10 00 00 F0.
  - No mem_we, done=1.
  - Random in_valid gaps show only one byte per in_valid&&in_ready.
- Abort: start pulsed after 6 bytes of a frame, with in_valid high that cycle.
  - Byte not accepted, busy=0, no write. The following full frame loads correctly.
- Timeout (LOADER_TIMEOUT_EN, TIMEOUT_CYC=16): send 3 bytes, then idle 16 clocks.
  - error=1, err_code=10.
  - Without the macro, still busy after 100 idle clocks.

Source files
------------

// File: rtl/mips32_prog_loader.sv
// mips32_prog_loader
//
// Byte-stream program loader that drives the write side of the MIPS32
// instruction/data memory. It receives one framed program image over a
// valid/ready byte interface. It assembles big-endian 32-bit words, writes them
// to consecutive word addresses, and checks the frame checksum. If the checksum
// is good, it releases the core through cpu_run.
//
// Frame layout, in byte order:
//   ADDR_HI ADDR_LO CNT_HI CNT_LO {4*N payload bytes, MSB first} CHK
// The 8-bit sum of every byte, including CHK, must be 0x00.
//
// Ports
//   clk        single clock, all logic on the rising edge
//   rst_n      synchronous active-low reset
//   start      one-cycle pulse that aborts any frame and re-arms the loader
//   in_valid   byte source has data
//   in_data    stream byte
//   in_ready   loader accepts a byte this cycle (combinational, independent
//              of in_valid)
//   mem_we     one-cycle write strobe per assembled word
//   mem_addr   memory word address (ADDR_W bits)
//   mem_wdata  memory write data
//   busy       frame reception in progress (after the first header byte)
//   done       last frame loaded with a good checksum
//   error      last frame failed
//   err_code   00 none, 01 checksum, 10 timeout
//   cpu_run    processor release, high only while loaded successfully
//
// Parameters
//   ADDR_W       memory word-address width
//   TIMEOUT_CYC  inter-byte timeout in clocks
//
// Build option
//   LOADER_TIMEOUT_EN  When defined, the loader aborts a frame with
//                      err_code 10 after TIMEOUT_CYC idle clocks while busy.
//                      When undefined, the loader waits indefinitely.

module mips32_prog_loader #(
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic              cpu_run
);

    typedef enum logic [2:0] {
        S_RESET,
        S_HDR,
        S_PAY,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    logic [1:0]        hdr_idx;
    logic [1:0]        byte_idx;
    logic [7:0]        addr_hi;
    logic [7:0]        addr_lo;
    logic [7:0]        cnt_hi;
    logic [7:0]        sum;
    logic [15:0]       words_left;
    logic [ADDR_W-1:0] addr;
    logic [23:0]       word_shift;

    logic              accept;
    logic [7:0]        sum_next;
    logic [15:0]       hdr_addr;
    logic [15:0]       hdr_count;
    logic              unused_ok;

`ifdef LOADER_TIMEOUT_EN
    logic [31:0]       idle_cnt;
`endif

    // A byte moves only in the receiving states. A start pulse blocks the
    // handshake, so the byte offered in the same cycle is never accepted.
    assign in_ready  = ((state == S_HDR) || (state == S_PAY) || (state == S_CHK)) && !start;
    assign accept    = in_valid && in_ready;
    assign sum_next  = sum + in_data;
    assign hdr_addr  = {addr_hi, addr_lo};
    assign hdr_count = {cnt_hi, in_data};

    // Header address bits above ADDR_W cannot reach the memory. They are
    // gathered here only so that they have a reader.
`ifdef LOADER_TIMEOUT_EN
    assign unused_ok = ^hdr_addr;
`else
    assign unused_ok = ^{hdr_addr, 32'(TIMEOUT_CYC)};
`endif

    // Loader FSM with registered outputs.
    // mem_we is set on the edge that accepts the fourth byte of a word, so the
    // write slot is exactly the following cycle. A start pulse arriving during
    // that slot cannot cancel the write, because the write is already on the
    // port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_RESET;
            hdr_idx    <= 2'd0;
            byte_idx   <= 2'd0;
            addr_hi    <= 8'h00;
            addr_lo    <= 8'h00;
            cnt_hi     <= 8'h00;
            sum        <= 8'h00;
            words_left <= 16'd0;
            addr       <= '0;
            word_shift <= 24'd0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= 2'b00;
            cpu_run    <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            idle_cnt   <= 32'd0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (start) begin
                state    <= S_RESET;
                busy     <= 1'b0;
                done     <= 1'b0;
                error    <= 1'b0;
                err_code <= 2'b00;
                cpu_run  <= 1'b0;
            end else begin
                case (state)
                    S_RESET: begin
                        hdr_idx    <= 2'd0;
                        byte_idx   <= 2'd0;
                        sum        <= 8'h00;
                        words_left <= 16'd0;
                        busy       <= 1'b0;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        err_code   <= 2'b00;
                        cpu_run    <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
                        idle_cnt   <= 32'd0;
`endif
                        state      <= S_HDR;
                    end

                    S_HDR: begin
                        if (accept) begin
                            sum     <= sum_next;
                            busy    <= 1'b1;
                            hdr_idx <= hdr_idx + 2'd1;
                            case (hdr_idx)
                                2'd0: addr_hi <= in_data;
                                2'd1: addr_lo <= in_data;
                                2'd2: cnt_hi  <= in_data;
                                default: begin
                                    addr       <= hdr_addr[ADDR_W-1:0];
                                    words_left <= hdr_count;
                                    byte_idx   <= 2'd0;
                                    // An empty program carries only the checksum.
                                    state      <= (hdr_count == 16'd0) ? S_CHK : S_PAY;
                                end
                            endcase
                        end
                    end

                    S_PAY: begin
                        if (accept) begin
                            sum        <= sum_next;
                            word_shift <= {word_shift[15:0], in_data};
                            byte_idx   <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                mem_we     <= 1'b1;
                                mem_addr   <= addr;
                                mem_wdata  <= {word_shift, in_data};
                                // Wrap past the top of memory is silent.
                                addr       <= addr + ADDR_W'(1);
                                words_left <= words_left - 16'd1;
                                if (words_left == 16'd1) begin
                                    state <= S_CHK;
                                end
                            end
                        end
                    end

                    S_CHK: begin
                        if (accept) begin
                            sum  <= sum_next;
                            busy <= 1'b0;
                            if (sum_next == 8'h00) begin
                                state   <= S_DONE;
                                done    <= 1'b1;
                                cpu_run <= 1'b1;
                            end else begin
                                state    <= S_ERR;
                                error    <= 1'b1;
                                err_code <= 2'b01;
                            end
                        end
                    end

                    S_DONE: state <= S_DONE;
                    S_ERR:  state <= S_ERR;
                    default: state <= S_RESET;
                endcase

`ifdef LOADER_TIMEOUT_EN
                // The idle counter runs only once the frame has begun. It
                // restarts on every accepted byte.
                if (busy && (state == S_HDR || state == S_PAY || state == S_CHK)) begin
                    if (accept) begin
                        idle_cnt <= 32'd0;
                    end else if (idle_cnt == 32'(TIMEOUT_CYC - 1)) begin
                        state    <= S_ERR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_code <= 2'b10;
                        idle_cnt <= 32'd0;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
                end else begin
                    idle_cnt <= 32'd0;
                end
`endif
            end
        end
    end

endmodule
